// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_pkg
// Description : Shared constants and types for the conv engine's output
//               writeback path: element/bus/accumulator/address widths, the
//               default output depth and the writeback FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

   // 20x20x64 elements packed two per memory word
   localparam int OUTPUT_DEPTH = 12800;
   localparam int ELEM_BW      = 8;
   localparam int BUS_BW       = 16;
   localparam int ACC_BW       = 20;
   localparam int ADDR_BW      = 14;
   localparam int BUF_AW       = 15;
   localparam int SHIFT_BW     = 5;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD_LO = 3'd1,
      RD_HI = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } wb_state_t;

endpackage
`default_nettype wire

// File: rtl/requant_sat.sv
`default_nettype none
// ============================================================================
// Module      : requant_sat
// Description : Combinational requantiser. Arithmetic right shift of a signed
//               accumulator, optional ReLU, then saturation to a signed
//               ELEM_BW-bit element.
// Ports       : acc     in  ACC_BW   signed accumulator
//               shift   in  SHIFT_BW arithmetic right-shift amount
//               relu_en in  1        clamp negative results to zero
//               q       out ELEM_BW  saturated signed element
// Revision    : 1.0 - initial release
// ============================================================================
module requant_sat
   import conv_pkg::*;
#(
   parameter int ACC_BW   = conv_pkg::ACC_BW,
   parameter int ELEM_BW  = conv_pkg::ELEM_BW,
   parameter int SHIFT_BW = conv_pkg::SHIFT_BW
)(
   input  logic signed [ACC_BW-1:0]   acc,
   input  logic        [SHIFT_BW-1:0] shift,
   input  logic                       relu_en,
   output logic signed [ELEM_BW-1:0]  q
);

   logic signed [ACC_BW-1:0]    w_shifted;
   logic signed [ACC_BW-1:0]    w_relu;
   // Bits from the element sign position upward; the value fits in ELEM_BW
   // bits exactly when these are all equal.
   logic [ACC_BW-ELEM_BW:0]     w_top;

   always_comb begin
      // Shifts of ACC_BW or more fill with the sign bit, giving 0 or -1.
      w_shifted = acc >>> shift;
      w_relu    = (relu_en && w_shifted[ACC_BW-1]) ? '0 : w_shifted;
      w_top     = w_relu[ACC_BW-1:ELEM_BW-1];
      if ((w_top == '0) || (w_top == '1)) begin
         q = w_relu[ELEM_BW-1:0];
      end else if (w_relu[ACC_BW-1]) begin
         q = {1'b1, {(ELEM_BW-1){1'b0}}};
      end else begin
         q = {1'b0, {(ELEM_BW-1){1'b1}}};
      end
   end

endmodule
`default_nettype wire

// File: rtl/output_writeback.sv
`default_nettype none
// ============================================================================
// Module      : output_writeback
// Description : Drains the conv output buffer to external memory. Each memory
//               word is built from two buffer reads (lo then hi element),
//               requantised to ELEM_BW bits and written over a valid/ready
//               bus. Issues a one-cycle done pulse after the last word.
// Ports       : clk, reset_n                 clock, async active-low reset
//               start, abort                 begin / cancel a writeback
//               base_addr, shift, relu_en    config, sampled on accepted start
//               buf_rd_en/addr/data          output-buffer sync read port
//               mem_wr_valid/ready/addr/data memory write channel
//               busy, done                   status
// Revision    : 1.0 - initial release
// ============================================================================
module output_writeback
   import conv_pkg::*;
#(
   parameter int OUTPUT_DEPTH = conv_pkg::OUTPUT_DEPTH,
   parameter int ELEM_BW      = conv_pkg::ELEM_BW,
   parameter int BUS_BW       = conv_pkg::BUS_BW,
   parameter int ACC_BW       = conv_pkg::ACC_BW,
   parameter int ADDR_BW      = conv_pkg::ADDR_BW,
   parameter int BUF_AW       = conv_pkg::BUF_AW
)(
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic                abort,
   input  logic [ADDR_BW-1:0]  base_addr,
   input  logic [SHIFT_BW-1:0] shift,
   input  logic                relu_en,
   output logic                buf_rd_en,
   output logic [BUF_AW-1:0]   buf_rd_addr,
   input  logic [ACC_BW-1:0]   buf_rd_data,
   output logic                mem_wr_valid,
   input  logic                mem_wr_ready,
   output logic [ADDR_BW-1:0]  mem_wr_addr,
   output logic [BUS_BW-1:0]   mem_wr_data,
   output logic                busy,
   output logic                done
);

   // Word counter width: element address is {k, lo/hi select}
   localparam int KW = BUF_AW - 1;

   wb_state_t                  r_state;
   wb_state_t                  w_state_nxt;

   logic [KW-1:0]              r_k;
   logic [ADDR_BW-1:0]         r_base;
   logic [SHIFT_BW-1:0]        r_shift;
   logic                       r_relu;
   logic [ELEM_BW-1:0]         r_lo;
   logic [ELEM_BW-1:0]         r_hi;
   logic                       r_hi_vld;

   logic signed [ELEM_BW-1:0]  w_q;
   logic [ELEM_BW-1:0]         w_hi;
   logic                       w_lsb;
   logic                       w_last;
   logic                       w_accept_start;

   // Both elements of a word come from the same read port, one cycle apart,
   // so a single requantiser serves the lo and hi captures.
   requant_sat #(
      .ACC_BW   (ACC_BW),
      .ELEM_BW  (ELEM_BW),
      .SHIFT_BW (SHIFT_BW)
   ) u_requant (
      .acc     (buf_rd_data),
      .shift   (r_shift),
      .relu_en (r_relu),
      .q       (w_q)
   );

   assign w_last         = (r_k == KW'(OUTPUT_DEPTH - 1));
   assign w_accept_start = (r_state == IDLE) && start && !abort;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      buf_rd_en    = 1'b0;
      w_lsb        = 1'b0;
      mem_wr_valid = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_state_nxt = RD_LO;
            end
         end
         RD_LO: begin
            buf_rd_en   = 1'b1;
            busy        = 1'b1;
            w_state_nxt = RD_HI;
         end
         RD_HI: begin
            buf_rd_en   = 1'b1;
            w_lsb       = 1'b1;
            busy        = 1'b1;
            w_state_nxt = WRITE;
         end
         WRITE: begin
            mem_wr_valid = 1'b1;
            busy         = 1'b1;
            if (mem_wr_ready) begin
               w_state_nxt = w_last ? DONE : RD_LO;
            end
         end
         DONE: begin
            done        = 1'b1;
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
      // Abort overrides every transition, including a start in IDLE.
      if (abort) begin
         w_state_nxt = IDLE;
      end
   end

   // ----------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_k      <= '0;
         r_base   <= '0;
         r_shift  <= '0;
         r_relu   <= 1'b0;
         r_lo     <= '0;
         r_hi     <= '0;
         r_hi_vld <= 1'b0;
      end else begin
         if (w_accept_start) begin
            r_k     <= '0;
            r_base  <= base_addr;
            r_shift <= shift;
            r_relu  <= relu_en;
         end
         // Lo element's read data is present during RD_HI.
         if (r_state == RD_HI) begin
            r_lo     <= w_q;
            r_hi_vld <= 1'b0;
         end
         // Hi element's read data is present only in the first WRITE cycle;
         // hold it so the bus word stays stable under backpressure.
         if ((r_state == WRITE) && !r_hi_vld) begin
            r_hi     <= w_q;
            r_hi_vld <= 1'b1;
         end
         if ((r_state == WRITE) && mem_wr_ready && !w_last) begin
            r_k <= r_k + KW'(1);
         end
      end
   end

   // First WRITE cycle forwards the hi element straight from the read port.
   assign w_hi        = r_hi_vld ? r_hi : w_q;
   assign buf_rd_addr = buf_rd_en ? {r_k, w_lsb} : '0;
   assign mem_wr_addr = mem_wr_valid ? (r_base + ADDR_BW'(r_k)) : '0;
   assign mem_wr_data = mem_wr_valid ? {w_hi, r_lo} : '0;

endmodule
`default_nettype wire

// File: tb/tb_output_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_output_writeback
// Description : Self-checking bench for output_writeback with OUTPUT_DEPTH=4.
//               A behavioural model computes expected words from the buffer
//               contents using plain integer arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_output_writeback;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic        abort;
   logic [13:0] base_addr;
   logic [4:0]  shift;
   logic        relu_en;
   logic        buf_rd_en;
   logic [14:0] buf_rd_addr;
   logic [19:0] buf_rd_data;
   logic        mem_wr_valid;
   logic        mem_wr_ready;
   logic [13:0] mem_wr_addr;
   logic [15:0] mem_wr_data;
   logic        busy;
   logic        done;

   output_writeback #(.OUTPUT_DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .abort        (abort),
      .base_addr    (base_addr),
      .shift        (shift),
      .relu_en      (relu_en),
      .buf_rd_en    (buf_rd_en),
      .buf_rd_addr  (buf_rd_addr),
      .buf_rd_data  (buf_rd_data),
      .mem_wr_valid (mem_wr_valid),
      .mem_wr_ready (mem_wr_ready),
      .mem_wr_addr  (mem_wr_addr),
      .mem_wr_data  (mem_wr_data),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   // Output buffer: 2*DEPTH signed accumulators, one-cycle synchronous read
   logic signed [19:0] bufm [8];
   always @(posedge clk) begin
      if (buf_rd_en) buf_rd_data <= bufm[buf_rd_addr[2:0]];
   end

   int total = 0;
   int bad   = 0;

   logic [13:0] got_addr [$];
   logic [15:0] got_data [$];
   int          first_valid_n;
   int          done_n;
   int          done_cnt;
   int          stab_err;

   logic [13:0] exp_addr [4];
   logic [15:0] exp_data [4];

   // Reference requantiser: integer shift, ReLU, clamp to int8
   function automatic logic [7:0] rq(input int acc, input int sh, input bit relu);
      int q;
      q = acc >>> sh;
      if (relu && q < 0) q = 0;
      if (q > 127) q = 127;
      if (q < -128) q = -128;
      return q[7:0];
   endfunction

   task automatic build_exp(input logic [13:0] b, input int sh, input bit rl);
      for (int k = 0; k < DEPTH; k++) begin
         exp_addr[k] = 14'((int'(b) + k) % 16384);
         exp_data[k] = {rq(bufm[2*k+1], sh, rl), rq(bufm[2*k], sh, rl)};
      end
   endtask

   task automatic fill_random();
      for (int i = 0; i < 8; i++) bufm[i] = 20'($urandom);
   endtask

   // Issues a start, then runs until a couple of cycles past done (or a
   // cycle budget), driving ready with the given percentage and logging
   // every accepted word. n counts clock edges after the start edge.
   task automatic do_run(input logic [13:0] b, input logic [4:0] sh, input bit rl,
                         input int pct, input int restart_at);
      logic        stall_prev;
      logic [13:0] pa;
      logic [15:0] pd;
      int          n;
      got_addr.delete();
      got_data.delete();
      first_valid_n = -1;
      done_n        = -1;
      done_cnt      = 0;
      stab_err      = 0;
      stall_prev    = 1'b0;
      pa            = '0;
      pd            = '0;
      @(negedge clk);
      start = 1'b1; base_addr = b; shift = sh; relu_en = rl;
      @(negedge clk);
      start = 1'b0;
      base_addr = 14'($urandom); shift = 5'($urandom); relu_en = 1'($urandom);
      n = 0;
      while (n < 200) begin
         start = (n == restart_at);
         if (done) begin
            done_cnt++;
            if (done_n < 0) done_n = n;
         end
         if (done_n >= 0 && n > done_n + 2) break;
         if (stall_prev && (!mem_wr_valid || mem_wr_addr !== pa || mem_wr_data !== pd))
            stab_err++;
         mem_wr_ready = ($urandom_range(0, 99) < pct);
         if (mem_wr_valid && first_valid_n < 0) first_valid_n = n;
         if (mem_wr_valid && mem_wr_ready) begin
            got_addr.push_back(mem_wr_addr);
            got_data.push_back(mem_wr_data);
         end
         stall_prev = mem_wr_valid && !mem_wr_ready;
         pa = mem_wr_addr;
         pd = mem_wr_data;
         @(negedge clk);
         n++;
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      total++;
      if ({buf_rd_en, mem_wr_valid, busy, done} !== 4'b0) begin
         bad++; $display("FAIL reset_ctrl got=%b exp=0000", {buf_rd_en, mem_wr_valid, busy, done});
      end
      total++;
      if ({buf_rd_addr, mem_wr_addr, mem_wr_data} !== 45'd0) begin
         bad++; $display("FAIL reset_bus got=%h exp=0", {buf_rd_addr, mem_wr_addr, mem_wr_data});
      end
   endtask

   task automatic test_basic();
      logic [13:0] b;
      for (int i = 0; i < 8; i++) bufm[i] = 20'(i);
      b = 14'($urandom_range(0, 1023));
      build_exp(b, 0, 1'b0);
      do_run(b, 5'd0, 1'b0, 100, -1);
      total++;
      if (got_data.size() !== 4) begin
         bad++; $display("FAIL basic_count got=%0d exp=4", got_data.size());
      end
      for (int k = 0; k < 4 && k < got_data.size(); k++) begin
         total++;
         if (got_data[k] !== 16'((2*k+1) * 256 + 2*k) || got_addr[k] !== 14'(b + 14'(k))) begin
            bad++; $display("FAIL basic_word%0d got=%h@%h exp=%h@%h", k, got_data[k], got_addr[k],
                            16'((2*k+1) * 256 + 2*k), 14'(b + 14'(k)));
         end
      end
      total++;
      if (first_valid_n !== 2) begin
         bad++; $display("FAIL basic_latency got=%0d exp=2", first_valid_n);
      end
      total++;
      if (done_n !== 12) begin
         bad++; $display("FAIL basic_done_time got=%0d exp=12", done_n);
      end
      total++;
      if (done_cnt !== 1 || busy !== 1'b0) begin
         bad++; $display("FAIL basic_done_pulse got=%0d/%b exp=1/0", done_cnt, busy);
      end
   endtask

   task automatic test_saturation();
      for (int r = 0; r < 2; r++) begin
         fill_random();
         bufm[0] = 20'sd300;
         bufm[1] = -20'sd300;
         build_exp(14'd0, 0, r[0]);
         do_run(14'd0, 5'd0, r[0], 100, -1);
         total++;
         if (got_data.size() < 1 || got_data[0] !== (r == 0 ? 16'h807F : 16'h007F)) begin
            bad++; $display("FAIL sat_relu%0d got=%h exp=%h", r,
                            got_data.size() ? got_data[0] : 16'hxxxx, r == 0 ? 16'h807F : 16'h007F);
         end
         for (int k = 1; k < 4 && k < got_data.size(); k++) begin
            total++;
            if (got_data[k] !== exp_data[k]) begin
               bad++; $display("FAIL sat_word%0d got=%h exp=%h", k, got_data[k], exp_data[k]);
            end
         end
      end
   endtask

   task automatic test_shift();
      fill_random();
      bufm[0] = -20'sd17;
      do_run(14'd0, 5'd4, 1'b0, 100, -1);
      total++;
      if (got_data.size() < 1 || got_data[0][7:0] !== 8'hFE) begin
         bad++; $display("FAIL shift4 got=%h exp=FE", got_data.size() ? got_data[0][7:0] : 8'hxx);
      end
      bufm[0] = -20'sd1;
      bufm[1] = 20'sd5;
      do_run(14'd0, 5'd31, 1'b0, 100, -1);
      total++;
      if (got_data.size() < 1 || got_data[0] !== 16'h00FF) begin
         bad++; $display("FAIL shift31 got=%h exp=00FF", got_data.size() ? got_data[0] : 16'hxxxx);
      end
   endtask

   task automatic test_random();
      logic [13:0] b;
      int          sh;
      bit          rl;
      for (int r = 0; r < 4; r++) begin
         fill_random();
         b  = 14'($urandom);
         sh = $urandom_range(0, 15);
         rl = 1'($urandom);
         build_exp(b, sh, rl);
         do_run(b, 5'(sh), rl, 100, -1);
         total++;
         if (got_data.size() !== 4) begin
            bad++; $display("FAIL rand%0d_count got=%0d exp=4", r, got_data.size());
         end
         for (int k = 0; k < 4 && k < got_data.size(); k++) begin
            total++;
            if (got_data[k] !== exp_data[k] || got_addr[k] !== exp_addr[k]) begin
               bad++; $display("FAIL rand%0d_word%0d got=%h@%h exp=%h@%h", r, k, got_data[k],
                               got_addr[k], exp_data[k], exp_addr[k]);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] ref_data [$];
      logic [13:0] b;
      fill_random();
      b = 14'($urandom);
      build_exp(b, 2, 1'b0);
      do_run(b, 5'd2, 1'b0, 100, -1);
      ref_data = got_data;
      do_run(b, 5'd2, 1'b0, 30, -1);
      total++;
      if (stab_err !== 0) begin
         bad++; $display("FAIL bp_stable got=%0d exp=0", stab_err);
      end
      total++;
      if (done_n < 0 || got_data.size() !== 4 || ref_data.size() !== 4) begin
         bad++; $display("FAIL bp_count got=%0d/%0d exp=4/4", got_data.size(), ref_data.size());
      end
      for (int k = 0; k < 4 && k < got_data.size() && k < ref_data.size(); k++) begin
         total++;
         if (got_data[k] !== ref_data[k] || got_data[k] !== exp_data[k] || got_addr[k] !== exp_addr[k]) begin
            bad++; $display("FAIL bp_word%0d got=%h exp=%h", k, got_data[k], exp_data[k]);
         end
      end
   endtask

   task automatic test_wrap();
      logic [13:0] want [4];
      want[0] = 14'h3FFE; want[1] = 14'h3FFF; want[2] = 14'h0000; want[3] = 14'h0001;
      fill_random();
      do_run(14'h3FFE, 5'd0, 1'b0, 100, -1);
      total++;
      if (got_addr.size() !== 4) begin
         bad++; $display("FAIL wrap_count got=%0d exp=4", got_addr.size());
      end
      for (int k = 0; k < 4 && k < got_addr.size(); k++) begin
         total++;
         if (got_addr[k] !== want[k]) begin
            bad++; $display("FAIL wrap_addr%0d got=%h exp=%h", k, got_addr[k], want[k]);
         end
      end
   endtask

   task automatic test_start_while_busy();
      fill_random();
      build_exp(14'h0123, 3, 1'b1);
      do_run(14'h0123, 5'd3, 1'b1, 100, 5);
      total++;
      if (got_data.size() !== 4 || done_cnt !== 1) begin
         bad++; $display("FAIL busy_start_count got=%0d/%0d exp=4/1", got_data.size(), done_cnt);
      end
      for (int k = 0; k < 4 && k < got_data.size(); k++) begin
         total++;
         if (got_data[k] !== exp_data[k] || got_addr[k] !== exp_addr[k]) begin
            bad++; $display("FAIL busy_start_word%0d got=%h@%h exp=%h@%h", k, got_data[k],
                            got_addr[k], exp_data[k], exp_addr[k]);
         end
      end
   endtask

   task automatic test_abort();
      int   n;
      int   nval;
      int   dcnt;
      logic prevv;
      bit   hit;
      fill_random();
      @(negedge clk);
      start = 1'b1; base_addr = 14'h0040; shift = 5'd0; relu_en = 1'b0;
      @(negedge clk);
      start = 1'b0;
      n = 0; nval = 0; prevv = 1'b0; hit = 1'b0;
      while (n < 100 && !hit) begin
         mem_wr_ready = 1'b1;
         if (mem_wr_valid && !prevv) nval++;
         prevv = mem_wr_valid;
         if (nval == 2) begin
            abort = 1'b1;
            hit   = 1'b1;
         end
         @(negedge clk);
         n++;
      end
      abort = 1'b0;
      total++;
      if (!hit) begin
         bad++; $display("FAIL abort_reach got=0 exp=1");
      end
      total++;
      if ({mem_wr_valid, busy, done} !== 3'b000) begin
         bad++; $display("FAIL abort_drop got=%b exp=000", {mem_wr_valid, busy, done});
      end
      dcnt = 0;
      repeat (8) begin
         @(negedge clk);
         if (done || busy) dcnt++;
      end
      total++;
      if (dcnt !== 0) begin
         bad++; $display("FAIL abort_idle got=%0d exp=0", dcnt);
      end
      build_exp(14'h0040, 0, 1'b0);
      do_run(14'h0040, 5'd0, 1'b0, 100, -1);
      total++;
      if (got_data.size() !== 4) begin
         bad++; $display("FAIL abort_restart_count got=%0d exp=4", got_data.size());
      end
      for (int k = 0; k < 4 && k < got_data.size(); k++) begin
         total++;
         if (got_data[k] !== exp_data[k] || got_addr[k] !== exp_addr[k]) begin
            bad++; $display("FAIL abort_restart_word%0d got=%h@%h exp=%h@%h", k, got_data[k],
                            got_addr[k], exp_data[k], exp_addr[k]);
         end
      end
   endtask

   task automatic test_start_abort_idle();
      int act;
      @(negedge clk);
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      act = 0;
      repeat (4) begin
         if (busy || buf_rd_en || mem_wr_valid) act++;
         @(negedge clk);
      end
      total++;
      if (act !== 0) begin
         bad++; $display("FAIL start_abort_idle got=%0d exp=0", act);
      end
   endtask

   task automatic test_reset_mid();
      int dcnt;
      fill_random();
      mem_wr_ready = 1'b1;
      @(negedge clk);
      start = 1'b1; base_addr = 14'h0100; shift = 5'd0; relu_en = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b0;
      #1;
      total++;
      if ({buf_rd_en, mem_wr_valid, busy, done} !== 4'b0 || {buf_rd_addr, mem_wr_addr, mem_wr_data} !== 45'd0) begin
         bad++; $display("FAIL reset_mid got=%b exp=0000", {buf_rd_en, mem_wr_valid, busy, done});
      end
      @(negedge clk);
      reset_n = 1'b1;
      dcnt = 0;
      repeat (15) begin
         @(negedge clk);
         if (done || busy || mem_wr_valid) dcnt++;
      end
      total++;
      if (dcnt !== 0) begin
         bad++; $display("FAIL reset_mid_quiet got=%0d exp=0", dcnt);
      end
   endtask

   initial begin
      reset_n      = 1'b0;
      start        = 1'b0;
      abort        = 1'b0;
      base_addr    = '0;
      shift        = '0;
      relu_en      = 1'b0;
      mem_wr_ready = 1'b1;
      for (int i = 0; i < 8; i++) bufm[i] = '0;
      repeat (3) @(negedge clk);
      test_reset();
      reset_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_basic();
      test_saturation();
      test_shift();
      test_random();
      test_backpressure();
      test_wrap();
      test_start_while_busy();
      test_abort();
      test_start_abort_idle();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
